period_meter: RTL and testbench

Measures the period and high time of a slow, asynchronous square wave, such as a divided clock or a blink/heartbeat line, in cycles of the system clock. It does the inverse of the team's clock divider, which makes a slow signal from a cycle count. This block recovers the cycle count from a slow signal. It sits beside the divider and wrapper I/O and gives software or a self-checking bench a registered period reading through a valid/ready handshake.

---
 rtl/period_meter_pkg.sv | 13 +
 rtl/sync_edge_det.sv | 43 ++++
 rtl/period_meter.sv | 156 +++++++++++++++
 tb/tb_period_meter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/period_meter_pkg.sv
// Shared types and default constants for the period meter.
package period_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } pm_state_t;

  localparam int PM_CNT_W   = 32;
  localparam int PM_TIMEOUT = 50_000_000;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer plus history flop, giving single-cycle rise/fall strobes.
// The fall output exists only when PERIOD_METER_HIGH_TIME_EN is defined.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
`ifdef PERIOD_METER_HIGH_TIME_EN
  ,
  output logic fall
`endif
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   hist_reg;

  for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
    if (gi == 0) begin : g_first
      always_ff @(posedge clk) begin
        if (rst) sync_reg[gi] <= 1'b0;
        else     sync_reg[gi] <= din;
      end
    end else begin : g_chain
      always_ff @(posedge clk) begin
        if (rst) sync_reg[gi] <= 1'b0;
        else     sync_reg[gi] <= sync_reg[gi-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) hist_reg <= 1'b0;
    else     hist_reg <= sync_reg[SYNC_STAGES-1];
  end

  assign rise = sync_reg[SYNC_STAGES-1] & ~hist_reg;
`ifdef PERIOD_METER_HIGH_TIME_EN
  assign fall = ~sync_reg[SYNC_STAGES-1] & hist_reg;
`endif

endmodule

// File: rtl/period_meter.sv
// Measures period (and optionally high time) of a slow asynchronous square wave in clk cycles.
// High-time capture is compiled in only when PERIOD_METER_HIGH_TIME_EN is defined.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int CNT_W       = PM_CNT_W,
  parameter int TIMEOUT     = PM_TIMEOUT,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             meas_en,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  input  logic             ready,
  output logic             overrun,
  output logic             stalled
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  pm_state_t        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] period_reg, period_next;
  logic             valid_reg, valid_next;
  logic             overrun_reg, overrun_next;
  logic             stalled_reg, stalled_next;
  logic             rise;

`ifdef PERIOD_METER_HIGH_TIME_EN
  logic             fall;
  logic [CNT_W-1:0] shadow_reg, shadow_next;
  logic [CNT_W-1:0] ht_reg, ht_next;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (sig_in),
    .rise (rise),
    .fall (fall)
  );
`else
  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (sig_in),
    .rise (rise)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      period_reg  <= '0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
      stalled_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      period_reg  <= period_next;
      valid_reg   <= valid_next;
      overrun_reg <= overrun_next;
      stalled_reg <= stalled_next;
    end
  end

`ifdef PERIOD_METER_HIGH_TIME_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_reg <= '0;
      ht_reg     <= '0;
    end else begin
      shadow_reg <= shadow_next;
      ht_reg     <= ht_next;
    end
  end
`endif

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    period_next  = period_reg;
    // A completed handshake frees the result; a new result below overrides this.
    valid_next   = valid_reg & ~ready;
    overrun_next = overrun_reg;
    stalled_next = stalled_reg;
`ifdef PERIOD_METER_HIGH_TIME_EN
    shadow_next  = shadow_reg;
    ht_next      = ht_reg;
`endif
    if (!meas_en) begin
      state_next   = IDLE;
      cnt_next     = '0;
      overrun_next = 1'b0;
      stalled_next = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          cnt_next   = '0;
          state_next = ARM;
        end
        ARM: begin
          if (rise) begin
            state_next   = RUN;
            cnt_next     = CNT_ONE;
            stalled_next = 1'b0;
          end else if (cnt_reg == TIMEOUT_C) begin
            stalled_next = 1'b1;
            cnt_next     = '0;
          end else if (cnt_reg != '1) begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end
        RUN: begin
          if (rise) begin
            period_next = cnt_reg;
            cnt_next    = CNT_ONE;
            valid_next  = 1'b1;
            if (valid_reg && !ready) overrun_next = 1'b1;
`ifdef PERIOD_METER_HIGH_TIME_EN
            ht_next = shadow_reg;
`endif
          end else begin
            if (cnt_reg == TIMEOUT_C) begin
              stalled_next = 1'b1;
              cnt_next     = '0;
              state_next   = ARM;
            end else if (cnt_reg != '1) begin
              cnt_next = cnt_reg + CNT_ONE;
            end
`ifdef PERIOD_METER_HIGH_TIME_EN
            if (fall) shadow_next = cnt_reg;
`endif
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign period  = period_reg;
  assign valid   = valid_reg;
  assign overrun = overrun_reg;
  assign stalled = stalled_reg;
`ifdef PERIOD_METER_HIGH_TIME_EN
  assign high_time = ht_reg;
`else
  assign high_time = '0;
`endif

endmodule

// File: tb/tb_period_meter.sv
// Scoreboard bench for period_meter: stimulus pushes expected (period, high_time) pairs,
// a negedge monitor pops them on every valid&&ready handshake. Honors PERIOD_METER_HIGH_TIME_EN.
module tb_period_meter;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 20;
  localparam int SYNC    = 2;
  localparam int LAT     = SYNC + 1;
`ifdef PERIOD_METER_HIGH_TIME_EN
  localparam bit HT_EN = 1'b1;
`else
  localparam bit HT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst, sig_in, meas_en, ready;
  logic [CNT_W-1:0] period, high_time;
  logic             valid, overrun, stalled;

  period_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .rst       (rst),
    .sig_in    (sig_in),
    .meas_en   (meas_en),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .ready     (ready),
    .overrun   (overrun),
    .stalled   (stalled)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int p;
    int h;
  } res_t;

  res_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   prev_h = -1;
  int   prev_l = 0;
  int   last_p = 0;
  int   last_h = 0;
  int   last_rise_cyc = 0;

  function automatic int exp_ht(int h);
    return HT_EN ? h : 0;
  endfunction

  task automatic check(string name, int act, int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One high/low pulse; the rise completes the previous pulse's measurement.
  task automatic pulse(int h, int l, bit push);
    sig_in        = 1'b1;
    last_rise_cyc = cyc;
    if (push && prev_h >= 0) begin
      exp_q.push_back('{prev_h + prev_l, exp_ht(prev_h)});
      last_p = prev_h + prev_l;
      last_h = exp_ht(prev_h);
    end
    tick(h);
    sig_in = 1'b0;
    tick(l);
    prev_h = h;
    prev_l = l;
  endtask

  // n pulses starting from ARM: the first rise only arms; the first `skip` results are not expected.
  task automatic burst(int n, int skip, int h, int l);
    int hh, ll;
    prev_h = -1;
    for (int i = 0; i < n; i++) begin
      hh = (h != 0) ? h : int'($urandom_range(2, 9));
      ll = (l != 0) ? l : int'($urandom_range(2, 9));
      pulse(hh, ll, i >= 1 + skip);
    end
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_period"}, int'(period), 0);
    check({tag, "_high_time"}, int'(high_time), 0);
    check({tag, "_valid"}, int'(valid), 0);
    check({tag, "_overrun"}, int'(overrun), 0);
    check({tag, "_stalled"}, int'(stalled), 0);
  endtask

  // Monitor: every accepted result must match the oldest outstanding expectation.
  always @(negedge clk) begin
    res_t e;
    if (!rst && valid && ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got period %0d, required no result", period);
      end else begin
        e = exp_q.pop_front();
        check("sb_period", int'(period), e.p);
        check("sb_high_time", int'(high_time), e.h);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1'b1; meas_en = 1'b0; ready = 1'b0; sig_in = 1'b0;
    repeat (3) begin
      tick(1);
      check_all_zero("reset");
    end
    rst = 1'b0; meas_en = 1'b1; ready = 1'b1;
    tick(10);

    // Toggle every 5 cycles, then 3-high/9-low duty cycle.
    burst(3, 0, 5, 5);
    tick(30);
    burst(4, 0, 3, 9);
    tick(30);

    // Randomised pulse trains.
    repeat (6) begin
      burst(int'($urandom_range(2, 5)), 0, 0, 0);
      tick(30);
    end

    // Timeout after the last rise; result retained; re-arm, then measure.
    burst(2, 0, 6, 6);
    k = last_rise_cyc;
    tick(k + LAT + TIMEOUT - 1 - cyc);
    check("stalled_early", int'(stalled), 0);
    tick(1);
    check("stalled_at_timeout", int'(stalled), 1);
    check("timeout_period_kept", int'(period), last_p);
    check("timeout_high_kept", int'(high_time), last_h);
    prev_h = -1;
    sig_in = 1'b1;
    tick(LAT);
    check("rearm_stalled_clear", int'(stalled), 0);
    check("rearm_no_valid", int'(valid), 0);
    tick(5 - LAT);
    sig_in = 1'b0;
    tick(5);
    prev_h = 5; prev_l = 5;
    pulse(5, 5, 1'b1);
    tick(10);
    check("after_rearm_drained", exp_q.size(), 0);
    tick(30);

    // Backpressure across two results.
    ready  = 1'b0;
    prev_h = -1;
    pulse(3, 4, 1'b0);
    pulse(4, 5, 1'b0);
    pulse(5, 6, 1'b1);
    check("bp_valid", int'(valid), 1);
    check("bp_overrun", int'(overrun), 1);
    check("bp_period_latest", int'(period), 9);
    check("bp_high_latest", int'(high_time), exp_ht(4));
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    check("bp_valid_cleared", int'(valid), 0);
    check("bp_overrun_sticky", int'(overrun), 1);
    meas_en = 1'b0;
    tick(1);
    check("disable_overrun", int'(overrun), 0);
    check("disable_stalled", int'(stalled), 0);
    meas_en = 1'b1;
    tick(30);

    // New result lands in the same cycle as a handshake.
    prev_h = -1;
    pulse(4, 4, 1'b0);
    pulse(5, 5, 1'b1);
    exp_q.push_back('{10, exp_ht(5)});
    sig_in = 1'b1;
    tick(LAT - 1);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    check("same_cycle_valid", int'(valid), 1);
    check("same_cycle_period", int'(period), 10);
    check("same_cycle_high", int'(high_time), exp_ht(5));
    check("same_cycle_overrun", int'(overrun), 0);
    tick(2);
    sig_in = 1'b0;
    tick(4);
    ready = 1'b1;
    tick(1);
    check("same_cycle_consumed", int'(valid), 0);
    tick(30);

    // Reset mid-period, then measure again.
    prev_h = -1;
    pulse(4, 3, 1'b0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_all_zero("mid_reset");
    tick(10);
    burst(3, 0, 4, 7);
    tick(30);

    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
